// File: rtl/seq_stim_pkg.sv
// Shared types and helpers for the a/b/c/d stimulus generator.
package seq_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Legal range of the a&&b -> d distance
    localparam logic [1:0] GD_MIN = 2'd1;
    localparam logic [1:0] GD_MAX = 2'd3;

    // Clamp the requested a&&b -> d distance into GD_MIN..GD_MAX
    function automatic logic [1:0] clamp_gd(input logic [1:0] g);
        logic [2:0] w;
        w = {1'b0, g};
        if (w < {1'b0, GD_MIN})
            return GD_MIN;
        else if (w > {1'b0, GD_MAX})
            return GD_MAX;
        else
            return g;
    endfunction

endpackage

// File: rtl/seq_gap_cnt.sv
// Loadable up-counter giving the cycle offset inside one repetition, with a
// terminal-count compare. One bit wider than the gap so 1+max_gap fits.
module seq_gap_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] off,
    output logic         term
);

    logic [W-1:0] off_reg;

    // Clear has priority so a repetition boundary restarts at offset 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            off_reg <= '0;
        else if (clr)
            off_reg <= '0;
        else if (en)
            off_reg <= off_reg + W'(1);
    end

    assign off  = off_reg;
    assign term = (off_reg == term_val);

endmodule

// File: rtl/seq_stim_gen.sv
// Registered a/b/c/d stimulus generator: on start, emits N back-to-back
// repetitions of a&&b, b, d (1..3 cycles after a&&b), c (programmable gap
// after b), then pulses done.
// Optional feature macro: SEQ_GEN_ERR_INJ_EN (suppresses d in the last
// repetition when err_inj is sampled high with start).
module seq_stim_gen
    import seq_stim_pkg::*;
#(
    parameter int GAP_W  = 4,
    parameter int REPS_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        gap_d,
    input  logic [GAP_W-1:0]  gap_c,
    input  logic [REPS_W-1:0] reps,
    input  logic              err_inj,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              busy,
    output logic              done
);

    seq_state_e        state_reg;
    logic [1:0]        gd_l_reg;
    logic [GAP_W-1:0]  gc_l_reg;
    logic [REPS_W-1:0] reps_l_reg;
    logic [REPS_W-1:0] rep_reg;
    logic              a_reg, b_reg, c_reg, d_reg, busy_reg, done_reg;

    logic [GAP_W:0]    off;
    logic              term;
    logic [GAP_W:0]    term_val;
    logic              last_rep;
    logic              cnt_clr;
    logic              cnt_en;
    logic              d_sup;

    // Config values as they would be latched on start
    logic [1:0]        gd_in;
    logic [GAP_W-1:0]  gd_ext;
    logic [GAP_W-1:0]  gc_in;
    logic [REPS_W-1:0] reps_in;

    assign gd_in   = clamp_gd(gap_d);
    assign gd_ext  = {{(GAP_W-2){1'b0}}, gd_in};
    assign gc_in   = (gap_c < gd_ext) ? gd_ext : gap_c;
    assign reps_in = (reps == '0) ? REPS_W'(1) : reps;

    // Terminal offset (c position) computed one bit wider so it never wraps
    assign term_val = {1'b0, gc_l_reg} + {{GAP_W{1'b0}}, 1'b1};
    assign last_rep = (rep_reg == reps_l_reg);
    assign cnt_clr  = ((state_reg == IDLE) && start) ||
                      ((state_reg == RUN) && term && !last_rep);
    assign cnt_en   = (state_reg == RUN);

    seq_gap_cnt #(.W(GAP_W + 1)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .term_val (term_val),
        .off      (off),
        .term     (term)
    );

`ifdef SEQ_GEN_ERR_INJ_EN
    logic inj_l_reg;

    // Capture the error-injection request together with the run config
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inj_l_reg <= 1'b0;
        else if ((state_reg == IDLE) && start)
            inj_l_reg <= err_inj;
    end

    assign d_sup = inj_l_reg && last_rep;
`else
    logic unused_err_inj;
    assign unused_err_inj = err_inj;
    assign d_sup = 1'b0;
`endif

    // Sequencer FSM: latches config, tracks repetitions, decodes registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            gd_l_reg   <= '0;
            gc_l_reg   <= '0;
            reps_l_reg <= '0;
            rep_reg    <= '0;
            a_reg      <= 1'b0;
            b_reg      <= 1'b0;
            c_reg      <= 1'b0;
            d_reg      <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    a_reg    <= 1'b0;
                    b_reg    <= 1'b0;
                    c_reg    <= 1'b0;
                    d_reg    <= 1'b0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                    if (start) begin
                        gd_l_reg   <= gd_in;
                        gc_l_reg   <= gc_in;
                        reps_l_reg <= reps_in;
                        rep_reg    <= REPS_W'(1);
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    a_reg    <= (off == '0);
                    b_reg    <= (off <= (GAP_W+1)'(1));
                    d_reg    <= (off == {{(GAP_W-1){1'b0}}, gd_l_reg}) && !d_sup;
                    c_reg    <= term;
                    busy_reg <= 1'b1;
                    done_reg <= 1'b0;
                    if (term) begin
                        if (last_rep)
                            state_reg <= DONE;
                        else
                            rep_reg <= rep_reg + REPS_W'(1);
                    end
                end
                DONE: begin
                    a_reg     <= 1'b0;
                    b_reg     <= 1'b0;
                    c_reg     <= 1'b0;
                    d_reg     <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    a_reg     <= 1'b0;
                    b_reg     <= 1'b0;
                    c_reg     <= 1'b0;
                    d_reg     <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign a    = a_reg;
    assign b    = b_reg;
    assign c    = c_reg;
    assign d    = d_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_seq_stim_gen.sv
// Self-checking bench for seq_stim_gen. Expected traces are built from the
// repetition/offset rules (per cycle after start) and compared every cycle.
module tb_seq_stim_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] gap_d;
    logic [3:0] gap_c;
    logic [2:0] reps;
    logic       err_inj;
    logic       a, b, c, d, busy, done;

    int tests_run = 0;
    int tests_failed = 0;

    seq_stim_gen #(.GAP_W(4), .REPS_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .gap_d   (gap_d),
        .gap_c   (gap_c),
        .reps    (reps),
        .err_inj (err_inj),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_GEN_ERR_INJ_EN
    localparam bit INJ_ENABLED = 1'b1;
`else
    localparam bit INJ_ENABLED = 1'b0;
`endif

    // Expected {a,b,c,d,busy,done} j cycles after the start edge
    function automatic logic [5:0] expect_vec(input int j, input int gdl, input int gcl,
                                              input int rl, input bit inj);
        int per, len, idx, r, o;
        logic [5:0] v;
        per = 2 + gcl;
        len = rl * per;
        v = 6'b0;
        if (j >= 1 && j <= len) begin
            idx = j - 1;
            r = idx / per + 1;
            o = idx % per;
            v[5] = (o == 0);
            v[4] = (o <= 1);
            v[3] = (o == per - 1);
            v[2] = (o == gdl) && !(inj && INJ_ENABLED && r == rl);
            v[1] = 1'b1;
        end else if (j == len + 1) begin
            v[0] = 1'b1;
        end
        return v;
    endfunction

    // One full run: start, then compare every cycle until idle again
    task automatic run_check(input logic [1:0] gd_in, input logic [3:0] gc_in,
                             input logic [2:0] reps_in, input bit inj, input bit noise,
                             input string name);
        int gdl, gcl, rl, len, fails0, dcnt;
        logic [5:0] got, exp;
        gdl = (gd_in == 2'd0) ? 1 : int'(gd_in);
        gcl = (int'(gc_in) < gdl) ? gdl : int'(gc_in);
        rl  = (reps_in == 3'd0) ? 1 : int'(reps_in);
        len = rl * (2 + gcl);
        fails0 = tests_failed;
        dcnt = 0;
        @(negedge clk);
        gap_d = gd_in; gap_c = gc_in; reps = reps_in; err_inj = inj; start = 1'b1;
        for (int j = 0; j <= len + 3; j++) begin
            @(negedge clk);
            if (j == 0 || !noise || j > len) start = 1'b0;
            else start = 1'($urandom_range(1, 0));
            if (noise) begin
                gap_d = 2'($urandom); gap_c = 4'($urandom);
                reps = 3'($urandom); err_inj = 1'($urandom);
            end
            got = {a, b, c, d, busy, done};
            exp = expect_vec(j, gdl, gcl, rl, inj);
            if (d) dcnt++;
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s cycle+%0d got abcd_busy_done=%b required=%b", name, j, got, exp);
            end
        end
        start = 1'b0;
        $display("[TB] run %s gd=%0d gc=%0d reps=%0d inj=%0d -> %0d cycles busy, %0d d pulses, %0d errs",
                 name, gd_in, gc_in, reps_in, inj, len, dcnt, tests_failed - fails0);
    endtask

    task automatic check_idle(input int cycles, input string name);
        logic [5:0] got;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            got = {a, b, c, d, busy, done};
            tests_run++;
            if (got !== 6'b0) begin
                tests_failed++;
                $display("FAIL %s cycle %0d got abcd_busy_done=%b required=000000", name, j, got);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        gap_d = 2'd2; gap_c = 4'd4; reps = 3'd2; err_inj = 1'b0;
        check_idle(3, "reset_held");
        start = 1'b0;
        rst_n = 1'b1;
        check_idle(3, "reset_released");
        $display("[TB] reset test done");
    endtask

    task automatic test_single();
        run_check(2'd2, 4'd4, 3'd1, 1'b0, 1'b0, "single_gd2_gc4");
    endtask

    task automatic test_back_to_back();
        run_check(2'd1, 4'd1, 3'd3, 1'b0, 1'b0, "b2b_reps3");
        run_check(2'd3, 4'd15, 3'd7, 1'b0, 1'b0, "b2b_max");
    endtask

    task automatic test_clamps();
        run_check(2'd0, 4'd0, 3'd0, 1'b0, 1'b0, "clamp_zero");
        run_check(2'd3, 4'd1, 3'd1, 1'b0, 1'b0, "clamp_gc_to_gd3");
    endtask

    task automatic test_ignore_and_abort();
        logic [5:0] got;
        run_check(2'd2, 4'd5, 3'd3, 1'b0, 1'b1, "start_ignored");
        @(negedge clk);
        gap_d = 2'd2; gap_c = 4'd6; reps = 3'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        got = {a, b, c, d, busy, done};
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_prerun busy got %b required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {a, b, c, d, busy, done};
        tests_run++;
        if (got !== 6'b0) begin
            tests_failed++;
            $display("FAIL abort_immediate got abcd_busy_done=%b required=000000", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle(25, "abort_no_done");
        run_check(2'd1, 4'd3, 3'd2, 1'b0, 1'b0, "after_abort");
        $display("[TB] ignore/abort test done");
    endtask

    task automatic test_err_inj();
        run_check(2'd2, 4'd3, 3'd2, 1'b1, 1'b0, "err_inj_reps2");
        run_check(2'd1, 4'd2, 3'd1, 1'b1, 1'b0, "err_inj_reps1");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_check(2'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'b1, "random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clamps();
        test_ignore_and_abort();
        test_err_inj();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
